// File: rtl/div_unit.sv
// Iterative 32-bit divider for the EX stage (DIV / DIVU).
// Radix-2 restoring algorithm, one quotient bit per cycle, with sign
// correction applied as the result is registered.
//
//  state | meaning
//  IDLE  | waiting for start_i; operands are captured on the start edge
//  BUSY  | 32 restoring iterations in progress; stall requested
//  DONE  | result valid; held while stall_i=1
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    input  logic        stall_i,
    output logic        streq_o,
    output logic        valid_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic [31:0] quotient_d, remainder_d;

    logic [31:0] mag_a, mag_b;
    logic [32:0] shifted, trial;
    logic [31:0] rem_step, quo_step;

    // Operand magnitudes and one restoring step on the partial remainder.
    always_comb begin
        mag_a    = (signed_i && dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
        mag_b    = (signed_i && divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;
        shifted  = {rem_q, quo_q[31]};
        trial    = shifted - {1'b0, dvs_q};
        // trial[32] set means the shifted remainder was below the divisor.
        rem_step = trial[32] ? shifted[31:0] : trial[31:0];
        quo_step = {quo_q[30:0], ~trial[32]};
    end

    // Next-state, datapath updates and the combinational stall request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        quotient_d  = quotient_o;
        remainder_d = remainder_o;
        streq_o     = 1'b0;

        case (state_q)
            IDLE: begin
                streq_o = start_i;
                if (start_i) begin
                    negq_d = signed_i & (dividend_i[31] ^ divisor_i[31]);
                    negr_d = signed_i & dividend_i[31];
                    quo_d  = mag_a;
                    dvs_d  = mag_b;
                    rem_d  = 32'd0;
                    cnt_d  = 6'd0;
                    if (divisor_i == 32'd0) begin
                        // Divide-by-zero bypasses the iterations entirely.
                        quotient_d  = 32'hFFFF_FFFF;
                        remainder_d = dividend_i;
                        state_d     = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                streq_o = 1'b1;
                rem_d   = rem_step;
                quo_d   = quo_step;
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    quotient_d  = negq_q ? (32'd0 - quo_step) : quo_step;
                    remainder_d = negr_q ? (32'd0 - rem_step) : rem_step;
                    state_d     = DONE;
                end
            end
            DONE: begin
                // start_i is deliberately ignored here: no back-to-back restart.
                if (!stall_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush beats everything, including a start in the same cycle.
        if (cancel_i) begin
            state_d     = IDLE;
            cnt_d       = 6'd0;
            streq_o     = 1'b0;
            quotient_d  = quotient_o;
            remainder_d = remainder_o;
        end
    end

    // State, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            rem_q       <= 32'd0;
            quo_q       <= 32'd0;
            dvs_q       <= 32'd0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            quotient_o  <= 32'd0;
            remainder_o <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            quotient_o  <= quotient_d;
            remainder_o <= remainder_d;
        end
    end

    // Result is valid exactly while in DONE.
    always_comb valid_o = (state_q == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus stall/cancel/reset sequences.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, signed_i, cancel_i, stall_i;
    logic [31:0] dividend_i, divisor_i;
    logic        streq_o, valid_o;
    logic [31:0] quotient_o, remainder_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] held_q, held_r;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .cancel_i    (cancel_i),
        .stall_i     (stall_i),
        .streq_o     (streq_o),
        .valid_o     (valid_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one operation in the current cycle (cycle 0) and follow it to DONE.
    task automatic run_vec(input int idx, input vec_t v);
        int  lat;
        logic streq_ok;
        start_i    = 1'b1;
        signed_i   = v.sgn;
        dividend_i = v.a;
        divisor_i  = v.b;
        #1;
        chk($sformatf("v%0d streq_c0", idx), {31'd0, streq_o}, 32'd1);
        lat      = 0;
        streq_ok = 1'b1;
        while (!valid_o && lat < 40) begin
            tick();
            lat++;
            // Operand changes after the start cycle must have no effect.
            dividend_i = $urandom;
            divisor_i  = $urandom;
            signed_i   = ~v.sgn;
            #1;
            if (!valid_o && !streq_o) streq_ok = 1'b0;
        end
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d quotient", idx), quotient_o, v.q);
        chk($sformatf("v%0d remainder", idx), remainder_o, v.r);
        chk($sformatf("v%0d streq_busy", idx), {31'd0, streq_ok}, 32'd1);
        chk($sformatf("v%0d streq_done", idx), {31'd0, streq_o}, 32'd0);
        held_q = v.q;
        held_r = v.r;
        start_i = 1'b0;
        tick();
        #1;
        chk($sformatf("v%0d idle_valid", idx), {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
        vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  1};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33};
        vecs[7]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          33};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
        vecs[9]  = '{1'b0, 32'd0,          32'd3,          32'd0,          32'd0,          33};
        vecs[10] = '{1'b0, 32'h1234_5678,  32'd16,         32'h0123_4567,  32'd8,          33};
        vecs[11] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33};
        vecs[12] = '{1'b0, 32'd7,          32'd7,          32'd1,          32'd0,          33};

        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0; stall_i = 1'b0;
        dividend_i = 32'd0; divisor_i = 32'd0;
        #12;
        chk("rst quotient", quotient_o, 32'd0);
        chk("rst remainder", remainder_o, 32'd0);
        chk("rst valid", {31'd0, valid_o}, 32'd0);
        chk("rst streq_idle", {31'd0, streq_o}, 32'd0);
        start_i = 1'b1;
        #1;
        chk("rst streq_start", {31'd0, streq_o}, 32'd1);
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Held result under stall; start_i kept high through DONE.
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
        for (int c = 0; c < 33; c++) tick();
        for (int k = 33; k <= 37; k++) begin
            stall_i = (k <= 36);
            #1;
            chk($sformatf("stall valid c%0d", k), {31'd0, valid_o}, 32'd1);
            chk($sformatf("stall streq c%0d", k), {31'd0, streq_o}, 32'd0);
            tick();
        end
        stall_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("stall idle_valid c38", {31'd0, valid_o}, 32'd0);
        chk("stall idle_streq c38", {31'd0, streq_o}, 32'd0);
        chk("stall quotient", quotient_o, 32'd14);
        chk("stall remainder", remainder_o, 32'd2);
        held_q = 32'd14; held_r = 32'd2;
        tick();

        // Cancel in cycle 10 of a 7/7 divide; outputs must keep 14/2.
        start_i = 1'b1; dividend_i = 32'd7; divisor_i = 32'd7;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        cancel_i = 1'b1;
        #1;
        chk("cancel streq c10", {31'd0, streq_o}, 32'd0);
        tick();
        cancel_i = 1'b0;
        #1;
        chk("cancel streq c11", {31'd0, streq_o}, 32'd0);
        chk("cancel valid c11", {31'd0, valid_o}, 32'd0);
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 30; c++) begin
                tick();
                #1;
                if (valid_o || streq_o) seen = 1'b1;
            end
            chk("cancel never_valid", {31'd0, seen}, 32'd0);
        end
        chk("cancel quotient held", quotient_o, held_q);
        chk("cancel remainder held", remainder_o, held_r);

        // Cancel together with start in IDLE: a divide-by-zero must not begin.
        start_i = 1'b1; cancel_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd0;
        #1;
        chk("cancel_start streq", {31'd0, streq_o}, 32'd0);
        tick();
        start_i = 1'b0; cancel_i = 1'b0;
        #1;
        chk("cancel_start valid", {31'd0, valid_o}, 32'd0);
        chk("cancel_start quotient", quotient_o, held_q);

        // Reset in cycle 20 of an operation clears the outputs immediately.
        tick();
        start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'hFFFF_FFF9; divisor_i = 32'd2;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst = 1'b1;
        #1;
        chk("midrst quotient", quotient_o, 32'd0);
        chk("midrst remainder", remainder_o, 32'd0);
        chk("midrst valid", {31'd0, valid_o}, 32'd0);
        tick();
        rst = 1'b0;
        run_vec(100, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
